// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares one single-port unified instruction/data memory between the
//    instruction-fetch unit (IF) and the data load/store unit (D). Requests
//    are arbitrated round-robin and served one at a time. Each access follows
//    the sequence SETUP -> STROBE -> DONE, so that the address and write data
//    are stable a full cycle before the memory strobe rises. The memory acts
//    on strobe rising edges, so exactly one strobe edge is produced per access.
//
// Ports:
//    clk, rst           system clock; synchronous active-high reset
//    if_req/if_addr     fetch request (held until if_done) and word address
//    if_rdata/if_done   registered fetched word; one-cycle completion pulse
//    d_req/d_we         data request (held until d_done); 1 = write
//    d_addr/d_wdata     data word address and store data
//    d_rdata/d_done     registered load data; one-cycle completion pulse
//    mem_addr/mem_wdata memory address and write data (stable SETUP..DONE)
//    mem_rdata          memory read data, sampled at the end of the strobe
//    mem_read/mem_write memory strobes, never high together
//    busy               high whenever the sequencer is not idle
//
// WAIT_CYC is the number of cycles a strobe is held high; legal range 1..15.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              busy
);

   // Sequencer states.
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Requester identifiers used for grant and last_grant.
   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // The strobe counter is loaded with WAIT_CYC-1 and the last strobe cycle
   // is the one in which it reads zero.
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

   // ----------------------------------------------------------------------
   // State registers and next-state values
   // ----------------------------------------------------------------------
   logic [1:0]        state_q,      state_d;
   logic              grant_q,      grant_d;
   logic              last_grant_q, last_grant_d;
   logic              we_q,         we_d;
   logic [3:0]        cnt_q,        cnt_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic              mem_read_q,   mem_read_d;
   logic              mem_write_q,  mem_write_d;
   logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
   logic              if_done_q,    if_done_d;
   logic              d_done_q,     d_done_d;

   // Arbitration helpers.
   logic idle_pick;     // requester chosen when granting from IDLE
   logic other_req;     // request of the requester not currently granted
   logic take_grant;    // a new grant is issued this cycle
   logic take_sel;      // which requester receives that grant

   // ----------------------------------------------------------------------
   // Round-robin choice from IDLE: on a tie the requester that was not
   // served last wins; otherwise whoever is asking.
   // ----------------------------------------------------------------------
   always_comb begin
      idle_pick = GNT_IF;
      if (if_req && d_req) begin
         idle_pick = (last_grant_q == GNT_D) ? GNT_IF : GNT_D;
      end else if (d_req) begin
         idle_pick = GNT_D;
      end
   end

   // In DONE only the opposite requester may be granted back-to-back; the
   // requester just served still holds req this cycle and must be ignored.
   assign other_req = (grant_q == GNT_IF) ? d_req : if_req;

   // ----------------------------------------------------------------------
   // Next-state logic
   // ----------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      take_grant   = 1'b0;
      take_sel     = GNT_IF;

      case (state_q)
         S_IDLE: begin
            if (if_req || d_req) begin
               take_grant = 1'b1;
               take_sel   = idle_pick;
               state_d    = S_SETUP;
            end
         end

         S_SETUP: begin
            // Address and data have been stable for this whole cycle, so
            // the strobe can rise on the next edge.
            state_d     = S_STROBE;
            mem_read_d  = ~we_q;
            mem_write_d = we_q;
            cnt_d       = CNT_LOAD;
         end

         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = S_DONE;
               // Read data is captured on the same edge that drops the
               // strobe; writes leave both rdata registers untouched.
               if (!we_q) begin
                  if (grant_q == GNT_IF) begin
                     if_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = mem_rdata;
                  end
               end
               if (grant_q == GNT_IF) begin
                  if_done_d = 1'b1;
               end else begin
                  d_done_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_DONE: begin
            last_grant_d = grant_q;
            if (other_req) begin
               take_grant = 1'b1;
               take_sel   = ~grant_q;
               state_d    = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Request inputs are sampled only here, at grant time. A fetch can
      // never write, and it leaves the write-data register as it was.
      if (take_grant) begin
         grant_d = take_sel;
         if (take_sel == GNT_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
         end else begin
            mem_addr_d  = if_addr;
            we_d        = 1'b0;
         end
      end
   end

   // ----------------------------------------------------------------------
   // State update. Reset mid-transaction drops the access without a done.
   // ----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= GNT_IF;
         last_grant_q <= GNT_D;     // IF wins the first tie after reset
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
      end
   end

   // ----------------------------------------------------------------------
   // Outputs
   // ----------------------------------------------------------------------
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign busy      = (state_q != S_IDLE);

endmodule
